// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg : shared types, constants and digit packing for BCD producers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGITS   = 4;
  localparam logic [3:0] NIBBLE_BLANK = 4'b1111;

  // Decoder expects each digit MSB-first at the low bit index.
  function automatic logic [3:0] pack_digit(input logic [3:0] nibble);
    return {nibble[0], nibble[1], nibble[2], nibble[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if : start/busy/done handshake and BCD result bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
);
  logic             inicio;
  logic [BIN_W-1:0] valor;
  logic             ocupado;
  logic             pronto;
  logic             overflow;
  logic [15:0]      registrador;

  modport master (
    output inicio, valor,
    input  ocupado, pronto, overflow, registrador
  );

  modport slave (
    input  inicio, valor,
    output ocupado, pronto, overflow, registrador
  );
endinterface

`default_nettype wire

// File: rtl/bcd_ajuste_digito.sv
// ---------------------------------------------------------------------------
// bcd_ajuste_digito : double-dabble add-3 correction for one BCD nibble
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_ajuste_digito (
  input  logic [3:0] digito_in,
  output logic [3:0] digito_out
);

  assign digito_out = (digito_in >= 4'd5) ? (digito_in + 4'd3) : digito_in;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq : one-bit-per-clock binary to packed BCD for the display decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic           clk,
  input  logic           rst_n,
  bin2bcd_seq_if.slave   bus
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_cap_q, ovf_cap_d;
  logic               overflow_q, overflow_d;
  logic               pronto_q, pronto_d;
  logic [BCD_W-1:0]   registrador_q, registrador_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [SR_W-1:0]    sr_shift;
  logic [BCD_W-1:0]   bcd_packed;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      bcd_ajuste_digito u_ajuste (
        .digito_in  (sr_q[BIN_W + 4*gi +: 4]),
        .digito_out (bcd_adj[4*gi +: 4])
      );
      assign bcd_packed[4*gi +: 4] = pack_digit(sr_shift[BIN_W + 4*gi +: 4]);
    end
  endgenerate

  // Add-3 happens before the shift; the bit falling off the top can only
  // be set for out-of-range inputs, so it is folded into the overflow flag.
  assign sr_shift = {bcd_adj[BCD_W-2:0], sr_q[BIN_W-1:0], 1'b0};

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    ovf_cap_d     = ovf_cap_q;
    overflow_d    = overflow_q;
    pronto_d      = 1'b0;
    registrador_d = registrador_q;

    case (state_q)
      IDLE: begin
        if (bus.inicio) begin
          sr_d       = {{BCD_W{1'b0}}, bus.valor};
          ovf_cap_d  = (32'(bus.valor) > MAX_VAL);
          overflow_d = 1'b0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        sr_d      = sr_shift;
        cnt_d     = cnt_q + 1'b1;
        ovf_cap_d = ovf_cap_q | bcd_adj[BCD_W-1];
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d       = DONE;
          pronto_d      = 1'b1;
          overflow_d    = ovf_cap_d;
          registrador_d = ovf_cap_d ? {BCD_DIGITS{NIBBLE_BLANK}} : bcd_packed;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      cnt_q         <= '0;
      ovf_cap_q     <= 1'b0;
      overflow_q    <= 1'b0;
      pronto_q      <= 1'b0;
      registrador_q <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      ovf_cap_q     <= ovf_cap_d;
      overflow_q    <= overflow_d;
      pronto_q      <= pronto_d;
      registrador_q <= registrador_d;
    end
  end

  assign bus.ocupado     = (state_q != IDLE);
  assign bus.pronto      = pronto_q;
  assign bus.overflow    = overflow_q;
  assign bus.registrador = registrador_q;

endmodule

`default_nettype wire
